// File: rtl/bp_be_pkg.sv
// Shared BE commit-trace definitions: record layout macros (timestamp-aware)
// and the trace-buffer FSM state enum.
// Optional feature macro: BP_BE_CMT_TRACE_TIMESTAMP_EN adds a cycle timestamp
// as the record MSBs.

`ifndef BP_BE_PKG_SV
`define BP_BE_PKG_SV

`ifdef BP_BE_CMT_TRACE_TIMESTAMP_EN
`define BP_BE_CMT_TRACE_TS_FIELD(ts_width_mp) logic [ts_width_mp-1:0] ts;
`define BP_BE_CMT_TRACE_TS_WIDTH(ts_width_mp) (ts_width_mp)
`else
`define BP_BE_CMT_TRACE_TS_FIELD(ts_width_mp)
`define BP_BE_CMT_TRACE_TS_WIDTH(ts_width_mp) (0 * (ts_width_mp))
`endif

// Packed record, MSB first: [ts,] seq, drop_flag, trap_v, ret_v, cause,
// rd_w_v, rd_addr, rd_data, instr, pc.
`define DECLARE_BP_BE_CMT_TRACE_REC_S(vaddr_width_mp, seq_width_mp, ts_width_mp) \
  typedef struct packed {                                                       \
    `BP_BE_CMT_TRACE_TS_FIELD(ts_width_mp)                                      \
    logic [seq_width_mp-1:0]   seq;                                             \
    logic                      drop_flag;                                       \
    logic                      trap_v;                                          \
    logic                      ret_v;                                           \
    logic [4:0]                cause;                                           \
    logic                      rd_w_v;                                          \
    logic [4:0]                rd_addr;                                         \
    logic [63:0]               rd_data;                                         \
    logic [31:0]               instr;                                           \
    logic [vaddr_width_mp-1:0] pc;                                              \
  } bp_be_cmt_trace_rec_s

// Fixed fields: drop_flag+trap_v+ret_v+cause+rd_w_v = 9, rd_addr 5,
// rd_data 64, instr 32.
`define BP_BE_CMT_TRACE_REC_WIDTH(vaddr_width_mp, seq_width_mp, ts_width_mp) \
  (`BP_BE_CMT_TRACE_TS_WIDTH(ts_width_mp) + (seq_width_mp) + 9 + 5 + 64 + 32 + (vaddr_width_mp))

`endif

package bp_be_pkg;

  // e_drop_pend: at least one commit was dropped since the last enqueue,
  // so the next enqueued record must carry drop_flag.
  typedef enum logic {
    e_normal    = 1'b0,
    e_drop_pend = 1'b1
  } bp_be_cmt_trace_state_e;

endpackage

// File: rtl/bp_be_cmt_trace_fifo.sv
// els_p x width_p 1r1w ring buffer for commit-trace records.
// Pointers and occupancy count reset asynchronously; storage does not.
// flush_i empties the buffer on the next edge and overrides enq/deq.

module bp_be_cmt_trace_fifo
  import bp_be_pkg::*;
#(
  parameter int width_p = 8,
  parameter int els_p   = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               flush_i,
  input  logic               enq_i,
  input  logic [width_p-1:0] data_i,
  input  logic               deq_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output logic               full_o
);

  localparam int ptr_width_lp = $clog2(els_p);
  localparam int cnt_width_lp = ptr_width_lp + 1;

  logic [width_p-1:0]      mem [els_p];
  logic [ptr_width_lp-1:0] wptr_r, rptr_r;
  logic [cnt_width_lp-1:0] cnt_r;

  // Record storage write.
  // NOTE: storage has no reset; validity is tracked by cnt_r alone, so
  // resetting the array would only cost flops and reset fanout.
  always_ff @(posedge clk_i) begin
    if (enq_i && !flush_i) begin
      mem[wptr_r] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping; flush wins over enq/deq.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cnt_r  <= '0;
    end else if (flush_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cnt_r  <= '0;
    end else begin
      wptr_r <= wptr_r + ptr_width_lp'(enq_i);
      rptr_r <= rptr_r + ptr_width_lp'(deq_i);
      cnt_r  <= cnt_r + cnt_width_lp'(enq_i) - cnt_width_lp'(deq_i);
    end
  end

  // Status comes only from the registered count, never from inputs.
  assign v_o    = (cnt_r != '0);
  assign full_o = (cnt_r == cnt_width_lp'(els_p));
  assign data_o = mem[rptr_r];

endmodule

// File: rtl/bp_be_cmt_trace_buffer.sv
// Commit-trace buffer: captures one record per commit-point event, buffers
// it, drains over valid/ready, tags records with a wrapping sequence number
// and flags the first record after dropped commits. Never back-pressures:
// overflow drops and counts (saturating).
// Optional feature macro: BP_BE_CMT_TRACE_TIMESTAMP_EN (free-running cycle
// counter sampled into the record MSBs at enqueue).

module bp_be_cmt_trace_buffer
  import bp_be_pkg::*;
#(
  parameter  int vaddr_width_p    = 39,
  parameter  int els_p            = 8,
  parameter  int seq_width_p      = 16,
  parameter  int drop_cnt_width_p = 16,
  parameter  int ts_width_p       = 32,
  localparam int rec_width_lp     = `BP_BE_CMT_TRACE_REC_WIDTH(vaddr_width_p, seq_width_p, ts_width_p)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        cmt_v_i,
  input  logic [vaddr_width_p-1:0]    cmt_pc_i,
  input  logic [31:0]                 cmt_instr_i,
  input  logic                        cmt_rd_w_v_i,
  input  logic [4:0]                  cmt_rd_addr_i,
  input  logic [63:0]                 cmt_rd_data_i,
  input  logic                        cmt_trap_v_i,
  input  logic                        cmt_ret_v_i,
  input  logic [4:0]                  cmt_cause_i,
  input  logic                        flush_i,
  output logic                        trace_v_o,
  input  logic                        trace_ready_i,
  output logic [rec_width_lp-1:0]     trace_data_o,
  output logic                        full_o,
  output logic [drop_cnt_width_p-1:0] drop_count_o
);

  `DECLARE_BP_BE_CMT_TRACE_REC_S(vaddr_width_p, seq_width_p, ts_width_p);

  bp_be_cmt_trace_rec_s   rec_li;
  bp_be_cmt_trace_state_e state_r, state_n;

  logic [seq_width_p-1:0]      seq_r;
  logic [drop_cnt_width_p-1:0] drop_cnt_r;
  logic fifo_v, fifo_full;
  logic cmt_fire, deq, enq, drop;

  // A flush discards the same-cycle commit and handshake entirely.
  assign cmt_fire = cmt_v_i & ~flush_i;
  assign deq      = fifo_v & trace_ready_i & ~flush_i;
  // A full buffer still accepts when a record leaves the same cycle.
  assign enq      = cmt_fire & (~fifo_full | deq);
  assign drop     = cmt_fire & fifo_full & ~deq;

`ifdef BP_BE_CMT_TRACE_TIMESTAMP_EN
  logic [ts_width_p-1:0] ts_r;

  // Free-running cycle counter, wraps.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) ts_r <= '0;
    else         ts_r <= ts_r + 1'b1;
  end
`endif

  // Sequence number advances on every non-flushed commit, accepted or
  // dropped, so consumers see gaps where records were lost.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)       seq_r <= '0;
    else if (cmt_fire) seq_r <= seq_r + 1'b1;
  end

  // Saturating count of dropped commits; flush leaves it untouched.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                   drop_cnt_r <= '0;
    else if (drop && !(&drop_cnt_r)) drop_cnt_r <= drop_cnt_r + 1'b1;
  end

  // Drop-pending FSM state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= e_normal;
    else         state_r <= state_n;
  end

  // Drop-pending FSM next state; flush returns to e_normal unconditionally.
  // NOTE: combinational blocks assign a default first so no path can leave
  // a variable unassigned and infer a latch.
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_normal:    if (drop) state_n = e_drop_pend;
      e_drop_pend: if (enq)  state_n = e_normal;
      default:     state_n = e_normal;
    endcase
    if (flush_i) state_n = e_normal;
  end

  // Record assembly; commit fields pass through unmodified.
  always_comb begin
    rec_li           = '0;
`ifdef BP_BE_CMT_TRACE_TIMESTAMP_EN
    rec_li.ts        = ts_r;
`endif
    rec_li.seq       = seq_r;
    rec_li.drop_flag = (state_r == e_drop_pend);
    rec_li.trap_v    = cmt_trap_v_i;
    rec_li.ret_v     = cmt_ret_v_i;
    rec_li.cause     = cmt_cause_i;
    rec_li.rd_w_v    = cmt_rd_w_v_i;
    rec_li.rd_addr   = cmt_rd_addr_i;
    rec_li.rd_data   = cmt_rd_data_i;
    rec_li.instr     = cmt_instr_i;
    rec_li.pc        = cmt_pc_i;
  end

  bp_be_cmt_trace_fifo #(
    .width_p (rec_width_lp),
    .els_p   (els_p)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (flush_i),
    .enq_i   (enq),
    .data_i  (rec_li),
    .deq_i   (deq),
    .v_o     (fifo_v),
    .data_o  (trace_data_o),
    .full_o  (fifo_full)
  );

  assign trace_v_o    = fifo_v;
  assign full_o       = fifo_full;
  assign drop_count_o = drop_cnt_r;

endmodule

// File: tb/tb_bp_be_cmt_trace_buffer.sv
// Self-checking bench for bp_be_cmt_trace_buffer: a behavioural scoreboard
// queue holds the expected records; a second instance with a 4-bit drop
// counter shares the stimulus to exercise saturation.

module tb_bp_be_cmt_trace_buffer;

  localparam int els_lp = 8;
`ifdef BP_BE_CMT_TRACE_TIMESTAMP_EN
  localparam int ts_w_lp = 32;
`else
  localparam int ts_w_lp = 0;
`endif
  localparam int rec_w_lp = ts_w_lp + 16 + 9 + 5 + 64 + 32 + 39;

  typedef logic [rec_w_lp-1:0] rec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmt_v, cmt_rd_w_v, cmt_trap_v, cmt_ret_v, flush, ready;
  logic [38:0] cmt_pc;
  logic [31:0] cmt_instr;
  logic [4:0]  cmt_rd_addr, cmt_cause;
  logic [63:0] cmt_rd_data;

  logic        trace_v, full, trace_v2, full2;
  rec_t        trace_data, trace_data2;
  logic [15:0] drop_count;
  logic [3:0]  drop_count2;

  rec_t        exp_q[$];
  logic [15:0] m_seq, m_drop;
  logic [3:0]  m_drop4;
  logic        m_pend;
`ifdef BP_BE_CMT_TRACE_TIMESTAMP_EN
  logic [31:0] m_ts;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bp_be_cmt_trace_buffer #(.els_p(els_lp)) dut (
    .clk_i(clk), .reset_i(reset), .cmt_v_i(cmt_v), .cmt_pc_i(cmt_pc),
    .cmt_instr_i(cmt_instr), .cmt_rd_w_v_i(cmt_rd_w_v), .cmt_rd_addr_i(cmt_rd_addr),
    .cmt_rd_data_i(cmt_rd_data), .cmt_trap_v_i(cmt_trap_v), .cmt_ret_v_i(cmt_ret_v),
    .cmt_cause_i(cmt_cause), .flush_i(flush), .trace_v_o(trace_v),
    .trace_ready_i(ready), .trace_data_o(trace_data), .full_o(full),
    .drop_count_o(drop_count)
  );

  bp_be_cmt_trace_buffer #(.els_p(els_lp), .drop_cnt_width_p(4)) dut_sat (
    .clk_i(clk), .reset_i(reset), .cmt_v_i(cmt_v), .cmt_pc_i(cmt_pc),
    .cmt_instr_i(cmt_instr), .cmt_rd_w_v_i(cmt_rd_w_v), .cmt_rd_addr_i(cmt_rd_addr),
    .cmt_rd_data_i(cmt_rd_data), .cmt_trap_v_i(cmt_trap_v), .cmt_ret_v_i(cmt_ret_v),
    .cmt_cause_i(cmt_cause), .flush_i(flush), .trace_v_o(trace_v2),
    .trace_ready_i(ready), .trace_data_o(trace_data2), .full_o(full2),
    .drop_count_o(drop_count2)
  );

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic rec_t make_rec();
    rec_t r;
`ifdef BP_BE_CMT_TRACE_TIMESTAMP_EN
    r = {m_ts, m_seq, m_pend, cmt_trap_v, cmt_ret_v, cmt_cause, cmt_rd_w_v,
         cmt_rd_addr, cmt_rd_data, cmt_instr, cmt_pc};
`else
    r = {m_seq, m_pend, cmt_trap_v, cmt_ret_v, cmt_cause, cmt_rd_w_v,
         cmt_rd_addr, cmt_rd_data, cmt_instr, cmt_pc};
`endif
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_seq   = '0;
    m_drop  = '0;
    m_drop4 = '0;
    m_pend  = 1'b0;
`ifdef BP_BE_CMT_TRACE_TIMESTAMP_EN
    m_ts    = '0;
`endif
  endtask

  // One clock: check outputs at the negedge, advance the model with the
  // inputs currently driven, then return 1 time unit after the posedge.
  task automatic cycle();
    logic do_deq, was_full;
    @(negedge clk);
    check("trace_v", trace_v, exp_q.size() != 0);
    check("full", full, exp_q.size() == els_lp);
    check("drop_count", drop_count, m_drop);
    check("sat_trace_v", trace_v2, exp_q.size() != 0);
    check("sat_full", full2, exp_q.size() == els_lp);
    check("sat_drop_count", drop_count2, m_drop4);
    if (trace_v && exp_q.size() != 0) begin
      check("trace_data", trace_data, exp_q[0]);
      check("sat_trace_data", trace_data2, exp_q[0]);
    end
    do_deq   = (exp_q.size() != 0) && ready;
    was_full = (exp_q.size() == els_lp);
    if (flush) begin
      exp_q.delete();
      m_pend = 1'b0;
    end else begin
      if (do_deq) void'(exp_q.pop_front());
      if (cmt_v) begin
        if (!was_full || do_deq) begin
          exp_q.push_back(make_rec());
          m_pend = 1'b0;
        end else begin
          if (m_drop != 16'hFFFF) m_drop++;
          if (m_drop4 != 4'hF) m_drop4++;
          m_pend = 1'b1;
        end
        m_seq++;
      end
    end
`ifdef BP_BE_CMT_TRACE_TIMESTAMP_EN
    m_ts++;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmt(input logic [38:0] pc);
    cmt_v       = 1'b1;
    cmt_pc      = pc;
    cmt_instr   = $urandom();
    cmt_rd_w_v  = 1'($urandom_range(1, 0));
    cmt_rd_addr = 5'($urandom_range(31, 0));
    cmt_rd_data = {$urandom(), $urandom()};
    cmt_trap_v  = 1'($urandom_range(1, 0));
    cmt_ret_v   = 1'($urandom_range(1, 0));
    cmt_cause   = 5'($urandom_range(31, 0));
  endtask

  task automatic commit(input logic [38:0] pc);
    set_cmt(pc);
    cycle();
    cmt_v = 1'b0;
  endtask

  task automatic rand_commits(input int n);
    for (int i = 0; i < n; i++) commit(39'({$urandom(), $urandom()}));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Called 1 time unit after a posedge; reset pulse lies between edges.
  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1;
    cmt_v = 1'b0; flush = 1'b0; ready = 1'b0;
    cmt_pc = '0; cmt_instr = '0; cmt_rd_w_v = 1'b0; cmt_rd_addr = '0;
    cmt_rd_data = '0; cmt_trap_v = 1'b0; cmt_ret_v = 1'b0; cmt_cause = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_trace_v", trace_v, 1'b0);
    check("reset_full", full, 1'b0);
    check("reset_drop_count", drop_count, 16'd0);
    reset = 1'b0;
    model_reset();

    // Three back-to-back commits drained at full rate.
    ready = 1'b1;
    commit(39'h0_8000_0000);
    commit(39'h0_8000_0004);
    commit(39'h0_8000_0008);
    idle(3);

    // Overflow: ten commits into an eight-deep stalled buffer.
    pulse_reset();
    ready = 1'b0;
    rand_commits(els_lp + 2);
    check("overflow_drop_count", drop_count, 16'd2);
    check("overflow_full", full, 1'b1);
    ready = 1'b1;
    rand_commits(1);
    idle(els_lp + 2);

    // Full buffer with simultaneous commit and handshake: no drop.
    ready = 1'b0;
    rand_commits(els_lp);
    ready = 1'b1;
    rand_commits(3);
    ready = 1'b0;
    idle(2);
    check("full_enq_deq_no_drop", drop_count, 16'd2);
    ready = 1'b1;
    idle(els_lp + 1);

    // Flush with a same-cycle commit and handshake.
    pulse_reset();
    ready = 1'b0;
    rand_commits(5);
    ready = 1'b1;
    flush = 1'b1;
    set_cmt(39'h0_8000_1000);
    cycle();
    flush = 1'b0;
    cmt_v = 1'b0;
    check("flush_empty", trace_v, 1'b0);
    commit(39'h0_8000_1004);
    idle(3);

    // Asynchronous reset mid-cycle with four records buffered.
    ready = 1'b0;
    rand_commits(4);
    #1;
    reset = 1'b1;
    #1;
    check("async_reset_trace_v", trace_v, 1'b0);
    check("async_reset_full", full, 1'b0);
    model_reset();
    #9;
    reset = 1'b0;
    ready = 1'b1;
    rand_commits(3);
    idle(2);

    // Saturation: fill, then twenty drops.
    ready = 1'b0;
    rand_commits(els_lp + 20);
    check("drop_count_20", drop_count, 16'd20);
    check("drop_count_sat", drop_count2, 4'hF);
    ready = 1'b1;
    rand_commits(2);
    idle(els_lp + 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
